// File: rtl/hermes_router_param.sv
`default_nettype none
// ============================================================================
// Module      : hermes_router_param
// Description : Five-port Hermes mesh router. One input FIFO per port, XY
//               routing, wormhole switching, credit-based flow control and a
//               round-robin arbiter per output. Optional per-output flit
//               counters are built when ROUTER_FLIT_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hermes_router_param #(
    parameter logic [7:0] ADDRESS      = 8'h11,
    parameter int         FLIT_WIDTH   = 16,
    parameter int         BUFFER_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [4:0]                rx,
    input  logic [5*FLIT_WIDTH-1:0]   data_in,
    output logic [4:0]                credit_o,
    output logic [4:0]                tx,
    output logic [5*FLIT_WIDTH-1:0]   data_out,
    input  logic [4:0]                credit_i,
    output logic [4:0]                clock_tx,
    output logic [5*32-1:0]           flit_count
);

    localparam int               PTR_W    = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);
    localparam logic [2:0]       EAST     = 3'd0;
    localparam logic [2:0]       WEST     = 3'd1;
    localparam logic [2:0]       NORTH    = 3'd2;
    localparam logic [2:0]       SOUTH    = 3'd3;
    localparam logic [2:0]       LOCAL    = 3'd4;
    localparam logic [3:0]       MY_X     = ADDRESS[7:4];
    localparam logic [3:0]       MY_Y     = ADDRESS[3:0];

    // ST_IDLE doubles as the request phase so a header can win arbitration
    // in the same cycle it reaches the FIFO head; ST_HEAD forwards the header.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAD    = 2'd1,
        ST_SIZE    = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    logic [FLIT_WIDTH-1:0] mem        [5][BUFFER_DEPTH];
    logic [PTR_W-1:0]      rd_ptr     [5];
    logic [PTR_W-1:0]      wr_ptr     [5];
    logic [CNT_W-1:0]      count      [5];
    logic [FLIT_WIDTH-1:0] head       [5];
    logic [2:0]            dest       [5];
    state_t                state      [5];
    state_t                state_nx   [5];
    logic [FLIT_WIDTH-1:0] pkt_cnt    [5];
    logic [FLIT_WIDTH-1:0] pkt_cnt_nx [5];
    logic [2:0]            owner      [5];
    logic [2:0]            rr_ptr     [5];
    logic [2:0]            grant_idx  [5];
    logic [4:0]            empty;
    logic [4:0]            push;
    logic [4:0]            pop;
    logic [4:0]            req;
    logic [4:0]            last;
    logic [4:0]            in_granted;
    logic [4:0]            own_valid;
    logic [4:0]            grant_valid;

    assign clock_tx = {5{clock}};

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic logic [2:0] xy_route(input logic [7:0] target);
        logic [2:0] dir;
        if (target[7:4] > MY_X)      dir = EAST;
        else if (target[7:4] < MY_X) dir = WEST;
        else if (target[3:0] > MY_Y) dir = NORTH;
        else if (target[3:0] < MY_Y) dir = SOUTH;
        else                         dir = LOCAL;
        return dir;
    endfunction

    // Per-input FIFO status, head decode and end-of-packet detection.
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            head[p]     = mem[p][rd_ptr[p]];
            empty[p]    = (count[p] == '0);
            credit_o[p] = (count[p] != FULL_CNT);
            push[p]     = rx[p] & credit_o[p];
            dest[p]     = xy_route(head[p][7:0]);
            req[p]      = (state[p] == ST_IDLE) & ~empty[p];
            last[p]     = ((state[p] == ST_SIZE) && (head[p] == '0)) ||
                          ((state[p] == ST_PAYLOAD) && (pkt_cnt[p] == FLIT_WIDTH'(1)));
        end
    end

    // Round-robin search per free output, starting after the last winner.
    always_comb begin
        grant_valid = '0;
        in_granted  = '0;
        for (int o = 0; o < 5; o++) begin
            grant_idx[o] = rr_ptr[o];
            if (!own_valid[o]) begin
                for (int k = 1; k <= 5; k++) begin
                    if (!grant_valid[o] && req[(int'(rr_ptr[o]) + k) % 5] &&
                        (dest[(int'(rr_ptr[o]) + k) % 5] == 3'(o))) begin
                        grant_valid[o] = 1'b1;
                        grant_idx[o]   = 3'((int'(rr_ptr[o]) + k) % 5);
                    end
                end
            end
        end
        for (int o = 0; o < 5; o++) begin
            if (grant_valid[o]) in_granted[grant_idx[o]] = 1'b1;
        end
    end

    // Crossbar: an owned output forwards its owner's head while credit allows.
    always_comb begin
        tx       = '0;
        pop      = '0;
        data_out = '0;
        for (int o = 0; o < 5; o++) begin
            if (own_valid[o]) begin
                data_out[o*FLIT_WIDTH +: FLIT_WIDTH] = head[owner[o]];
                tx[o] = ~empty[owner[o]] & credit_i[o];
            end
        end
        for (int o = 0; o < 5; o++) begin
            if (tx[o]) pop[owner[o]] = 1'b1;
        end
    end

    // Output ownership and round-robin pointers; released on the final pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            own_valid <= '0;
            for (int o = 0; o < 5; o++) begin
                owner[o]  <= '0;
                rr_ptr[o] <= LOCAL;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (grant_valid[o]) begin
                    own_valid[o] <= 1'b1;
                    owner[o]     <= grant_idx[o];
                    rr_ptr[o]    <= grant_idx[o];
                end else if (tx[o] && last[owner[o]]) begin
                    own_valid[o] <= 1'b0;
                end
            end
        end
    end

    // FIFO pointers and occupancy; full-with-pop does not reopen credit early.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 5; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
                if (push[p] && !pop[p])      count[p] <= count[p] + 1'b1;
                else if (!push[p] && pop[p]) count[p] <= count[p] - 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        for (int p = 0; p < 5; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= data_in[p*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    // Input packet FSM state and payload counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 5; p++) begin
                state[p]   <= ST_IDLE;
                pkt_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 5; p++) begin
                state[p]   <= state_nx[p];
                pkt_cnt[p] <= pkt_cnt_nx[p];
            end
        end
    end

    // Input packet FSM: walk header, size and payload flits as they pop.
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            state_nx[p]   = state[p];
            pkt_cnt_nx[p] = pkt_cnt[p];
            case (state[p])
                ST_IDLE:    if (in_granted[p]) state_nx[p] = ST_HEAD;
                ST_HEAD:    if (pop[p]) state_nx[p] = ST_SIZE;
                ST_SIZE: begin
                    if (pop[p]) begin
                        pkt_cnt_nx[p] = head[p];
                        state_nx[p]   = (head[p] == '0) ? ST_IDLE : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (pop[p]) begin
                        pkt_cnt_nx[p] = pkt_cnt[p] - 1'b1;
                        if (pkt_cnt[p] == FLIT_WIDTH'(1)) state_nx[p] = ST_IDLE;
                    end
                end
                default:    state_nx[p] = ST_IDLE;
            endcase
        end
    end

`ifdef ROUTER_FLIT_COUNT_EN
    logic [31:0] flit_cnt [5];

    // Per-output transmitted-flit counters, wrapping at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < 5; o++) flit_cnt[o] <= '0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (tx[o]) flit_cnt[o] <= flit_cnt[o] + 32'd1;
            end
        end
    end

    // Pack counters onto the flat output bus.
    always_comb begin
        for (int o = 0; o < 5; o++) flit_count[o*32 +: 32] = flit_cnt[o];
    end
`else
    assign flit_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hermes_router_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_hermes_router_param
// Description : Self-checking bench for hermes_router_param. A packet-level
//               reference model tracks flits held in each input FIFO and
//               checks every forwarded flit belongs, in order, to a whole
//               packet routed by XY rules. Counters are checked against
//               ROUTER_FLIT_COUNT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hermes_router_param;

    localparam int FW    = 16;
    localparam int DEPTH = 4;
`ifdef ROUTER_FLIT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [4:0]        rx;
    logic [5*FW-1:0]   data_in;
    logic [4:0]        credit_o;
    logic [4:0]        tx;
    logic [5*FW-1:0]   data_out;
    logic [4:0]        credit_i;
    logic [4:0]        clock_tx;
    logic [5*32-1:0]   flit_count;

    always #5 clock = ~clock;

    hermes_router_param #(
        .ADDRESS      (8'h11),
        .FLIT_WIDTH   (FW),
        .BUFFER_DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .data_in    (data_in),
        .credit_o   (credit_o),
        .tx         (tx),
        .data_out   (data_out),
        .credit_i   (credit_i),
        .clock_tx   (clock_tx),
        .flit_count (flit_count)
    );

    // reference model state
    logic [FW-1:0] pend_q [5][$];   // flits waiting to be offered on rx
    logic [FW-1:0] fifo_q [5][$];   // flits accepted and not yet forwarded
    int            out_src   [5];
    int            out_phase [5];   // 0 free, 1 expecting size, 2 payload
    int            out_left  [5];
    bit            in_busy   [5];
    logic [31:0]   model_cnt [5];
    // statistics for directed checks
    int            first_push [5];
    int            first_tx   [5];
    int            last_tx    [5];
    int            tx_cnt     [5];
    bit            low_seen   [5];
    int            served     [5][$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rate = 100;
    int pkt_seq = 0;
    bit rand_credit = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int route(input logic [7:0] t);
        int x = int'(t[7:4]);
        int y = int'(t[3:0]);
        if (x > 1) return 0;
        if (x < 1) return 1;
        if (y > 1) return 2;
        if (y < 1) return 3;
        return 4;
    endfunction

    function automatic bit model_idle();
        bit idle = 1'b1;
        for (int p = 0; p < 5; p++) begin
            if (pend_q[p].size() != 0 || fifo_q[p].size() != 0 || out_phase[p] != 0) idle = 1'b0;
        end
        return idle;
    endfunction

    task automatic clear_stats();
        for (int p = 0; p < 5; p++) begin
            first_push[p] = -1;
            first_tx[p]   = -1;
            last_tx[p]    = -1;
            tx_cnt[p]     = 0;
            low_seen[p]   = 1'b0;
            served[p].delete();
        end
    endtask

    task automatic clear_model();
        for (int p = 0; p < 5; p++) begin
            pend_q[p].delete();
            fifo_q[p].delete();
            out_src[p]   = -1;
            out_phase[p] = 0;
            out_left[p]  = 0;
            in_busy[p]   = 1'b0;
            model_cnt[p] = '0;
        end
    endtask

    task automatic add_pkt(input int p, input logic [7:0] tgt, input int n);
        pend_q[p].push_back({3'(p), 5'(pkt_seq), tgt});
        pkt_seq++;
        pend_q[p].push_back(16'(n));
        for (int i = 0; i < n; i++) pend_q[p].push_back(16'($urandom));
    endtask

    // offer the next pending flit on each port (credit is not consulted)
    task automatic drive();
        for (int p = 0; p < 5; p++) begin
            if (pend_q[p].size() > 0 && $urandom_range(99) < rate) begin
                rx[p] = 1'b1;
                data_in[p*FW +: FW] = pend_q[p][0];
            end else begin
                rx[p] = 1'b0;
                data_in[p*FW +: FW] = 16'($urandom);
            end
        end
    endtask

    // check this cycle's outputs, update the model, advance one clock
    task automatic tick();
        logic [4:0]    acc;
        logic [FW-1:0] d;
        logic [FW-1:0] e;
        int            found;
        int            s;
        #1;
        for (int p = 0; p < 5; p++) begin
            chk("credit_o", credit_o[p], fifo_q[p].size() < DEPTH);
            if (!credit_o[p]) low_seen[p] = 1'b1;
            acc[p] = rx[p] && (fifo_q[p].size() < DEPTH);
        end
        for (int o = 0; o < 5; o++) begin
            chk("flit_count", flit_count[o*32 +: 32], CNT_EN ? model_cnt[o] : 32'd0);
            if (!credit_i[o]) chk("tx_without_credit", tx[o], 1'b0);
            else if (out_phase[o] != 0 && fifo_q[out_src[o]].size() > 0) chk("tx_stalled", tx[o], 1'b1);
            if (tx[o]) begin
                d = data_out[o*FW +: FW];
                model_cnt[o] = model_cnt[o] + 32'd1;
                tx_cnt[o]++;
                if (first_tx[o] < 0) first_tx[o] = cyc;
                last_tx[o] = cyc;
                if (out_phase[o] == 0) begin
                    found = -1;
                    for (int p = 0; p < 5; p++) begin
                        if (found < 0 && !in_busy[p] && fifo_q[p].size() > 0) begin
                            if (fifo_q[p][0] == d && route(d[7:0]) == o) found = p;
                        end
                    end
                    chk("header_match", found >= 0, 1'b1);
                    if (found >= 0) begin
                        void'(fifo_q[found].pop_front());
                        in_busy[found] = 1'b1;
                        out_src[o]     = found;
                        out_phase[o]   = 1;
                        served[o].push_back(found);
                    end
                end else begin
                    s = out_src[o];
                    chk("flit_available", fifo_q[s].size() > 0, 1'b1);
                    if (fifo_q[s].size() > 0) begin
                        e = fifo_q[s].pop_front();
                        chk("data_out", d, e);
                        if (out_phase[o] == 1) begin
                            out_left[o]  = int'(e);
                            out_phase[o] = 2;
                        end else begin
                            out_left[o]--;
                        end
                        if (out_left[o] == 0) begin
                            out_phase[o] = 0;
                            in_busy[s]   = 1'b0;
                        end
                    end
                end
            end
        end
        for (int p = 0; p < 5; p++) begin
            if (acc[p]) begin
                fifo_q[p].push_back(data_in[p*FW +: FW]);
                void'(pend_q[p].pop_front());
                if (first_push[p] < 0) first_push[p] = cyc;
            end
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic cycle();
        drive();
        tick();
    endtask

    task automatic run(input int budget);
        int n = 0;
        while (!model_idle() && n < budget) begin
            if (rand_credit) begin
                for (int o = 0; o < 5; o++) credit_i[o] = ($urandom_range(9) < 8);
            end
            cycle();
            n++;
        end
        chk("drain_done", model_idle(), 1'b1);
        credit_i = '1;
    endtask

    task automatic run_until_east(input int flits);
        int n = 0;
        while (tx_cnt[0] < flits && n < 50) begin
            cycle();
            n++;
        end
        chk("east_progress", tx_cnt[0] >= flits, 1'b1);
    endtask

    initial begin
        int exp_order [4] = '{1, 3, 1, 3};
        rx       = '0;
        data_in  = '0;
        credit_i = '1;
        reset    = 1'b1;
        clear_model();
        clear_stats();
        @(negedge clock);
        #1;
        chk("rst_credit_o",   credit_o, 5'h1f);
        chk("rst_tx",         tx, 5'h00);
        chk("rst_data_out",   |data_out, 1'b0);
        chk("rst_flit_count", |flit_count, 1'b0);
        chk("clock_tx",       clock_tx, {5{clock}});
        reset = 1'b0;
        @(negedge clock);

        // LOCAL -> EAST, size 2, fixed payload
        clear_stats();
        pend_q[4].push_back(16'h8021);
        pend_q[4].push_back(16'h0002);
        pend_q[4].push_back(16'h00A5);
        pend_q[4].push_back(16'h005A);
        run(40);
        chk("t1_latency",  first_tx[0] - first_push[4], 2);
        chk("t1_tx_count", tx_cnt[0], 4);
        chk("t1_back2back", last_tx[0] - first_tx[0], 3);
        chk("t1_credit_never_low", low_seen[4], 1'b0);

        // WEST and SOUTH contend for LOCAL, two packets each
        clear_stats();
        add_pkt(1, 8'h11, 1);
        add_pkt(1, 8'h11, 1);
        add_pkt(3, 8'h11, 1);
        add_pkt(3, 8'h11, 1);
        run(80);
        chk("t2_packets", served[4].size(), 4);
        for (int i = 0; i < 4 && i < served[4].size(); i++) chk("t2_rr_order", served[4][i], exp_order[i]);
        chk("t2_flits", tx_cnt[4], 12);

        // concurrent EAST->WEST and LOCAL->NORTH
        clear_stats();
        add_pkt(0, 8'h01, 1);
        add_pkt(4, 8'h12, 1);
        run(40);
        chk("t3_same_start", first_tx[1], first_tx[2]);
        chk("t3_west_flits", tx_cnt[1], 3);
        chk("t3_north_flits", tx_cnt[2], 3);

        // downstream stall mid-payload
        clear_stats();
        add_pkt(4, 8'h21, 4);
        run_until_east(3);
        credit_i[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive();
            #1;
            chk("t4_stall_tx", tx[0], 1'b0);
            if (fifo_q[4].size() > 0) chk("t4_stall_data", data_out[FW-1:0], fifo_q[4][0]);
            tick();
        end
        credit_i[0] = 1'b1;
        run(40);
        chk("t4_flits", tx_cnt[0], 6);

        // fill the LOCAL FIFO behind a blocked output
        clear_stats();
        credit_i[0] = 1'b0;
        add_pkt(4, 8'h21, 3);
        for (int n = 0; n < 20 && fifo_q[4].size() < DEPTH; n++) cycle();
        chk("t5_filled", fifo_q[4].size(), DEPTH);
        for (int i = 0; i < 2; i++) begin
            drive();
            #1;
            chk("t5_full_credit", credit_o[4], 1'b0);
            tick();
        end
        credit_i[0] = 1'b1;
        drive();
        #1;
        chk("t5_release_tx", tx[0], 1'b1);
        chk("t5_credit_same_cycle", credit_o[4], 1'b0);
        tick();
        drive();
        #1;
        chk("t5_credit_next_cycle", credit_o[4], 1'b1);
        tick();
        run(40);
        chk("t5_flits", tx_cnt[0], 5);

        // reset mid-payload
        clear_stats();
        add_pkt(4, 8'h21, 4);
        run_until_east(3);
        reset = 1'b1;
        rx    = '0;
        #1;
        chk("t6_tx",         tx, 5'h00);
        chk("t6_data_out",   |data_out, 1'b0);
        chk("t6_credit_o",   credit_o, 5'h1f);
        chk("t6_flit_count", |flit_count, 1'b0);
        clear_model();
        @(negedge clock);
        reset = 1'b0;
        clear_stats();
        add_pkt(4, 8'h21, 1);
        run(40);
        drive();
        #1;
        chk("t6_count_after", flit_count[31:0], CNT_EN ? 32'd3 : 32'd0);
        tick();

        // randomized traffic with random backpressure
        clear_stats();
        for (int i = 0; i < 60; i++) begin
            add_pkt($urandom_range(4), {4'($urandom_range(2)), 4'($urandom_range(2))}, $urandom_range(3));
        end
        rate        = 70;
        rand_credit = 1'b1;
        run(4000);
        rand_credit = 1'b0;
        rate        = 100;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hermes_router_param.md
# hermes_router_param

Parametrised five-port Hermes mesh router: successor to the fixed 16-bit router, generalising flit width and input-buffer depth and adding per-output round-robin arbitration with concurrent packet switching. One input FIFO per port, XY routing, wormhole switching, credit-based flow control. One instance per mesh tile.

## Interface
- ADDRESS, 8'h11, router coordinate; [7:4] = X, [3:0] = Y
- FLIT_WIDTH, 16, flit width in bits; minimum 8
- BUFFER_DEPTH, 4, input FIFO depth per port; power of two, minimum 2
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- rx  in  5  flit valid per input port (index 0 EAST, 1 WEST, 2 NORTH, 3 SOUTH, 4 LOCAL)
- data_in  in  5*FLIT_WIDTH  port p at [p*FLIT_WIDTH +: FLIT_WIDTH]
- credit_o  out  5  input FIFO p not full
- tx  out  5  flit valid per output port
- data_out  out  5*FLIT_WIDTH  packing as data_in
- credit_i  in  5  downstream can accept a flit on output p
- clock_tx  out  5  {5{clock}}
- flit_count  out  5*32  per-output transmitted-flit counters (see Configuration)

## Operation
- Packet: flit 0 header, target = low 8 bits; flit 1 size N (unsigned, full width); N payload flits. Length N+2.
- Input write: FIFO p pushes data_in[p] on edge where rx[p]=1 and credit_o[p]=1; rx ignored while credit_o[p]=0.
- Per input FSM: IDLE (head is header, no grant) -> REQ (request computed output) -> SIZE (grant held, forward size flit, load counter=N) -> PAYLOAD (forward, decrement per pop) -> IDLE after last payload pop. N=0: release on size-flit pop.
- XY routing, unsigned compare: tx>X -> EAST; tx<X -> WEST; else ty>Y -> NORTH; ty<Y -> SOUTH; else LOCAL. U-turn routes not special-cased.
- Arbitration: one round-robin arbiter per output; at most one grant per output per cycle; search starts at input after last granted; pointer resets to LOCAL (EAST searched first). Different outputs grant concurrently.
- Output owned by granted input until its final flit pops; other requests wait.
- Forwarding: tx[o]=1 iff owned, owner FIFO non-empty, credit_i[o]=1; data_out[o] = owner head flit; pop on that edge. data_out undefined-but-stable (holds head) when tx=0.

## Timing
- Reset values: credit_o=5'b11111, tx=0, data_out=0, FIFOs empty, all FSMs IDLE, arbiter pointers LOCAL, flit_count=0.
- tx, data_out combinational from registered state plus credit_i; credit_o registered-state only (no rx path).
- Flit pushed at edge k is at FIFO head in cycle k+1; header request cycle k+1, grant at edge k+1; header on tx earliest cycle k+2. Thereafter one flit per cycle per output while credit_i=1 and data available.
- Full FIFO with simultaneous pop: credit_o stays 0 that cycle (no bypass); rises next cycle.
- credit_i low: hold flit, no pop, grant retained.
- Reset mid-packet: FIFOs flushed, grants dropped, partial packet lost; no recovery.

## Configuration
- ROUTER_FLIT_COUNT_EN defined: flit_count[o*32 +: 32] increments on each edge with tx[o]=1, wraps 32'hFFFFFFFF -> 0, cleared by reset.
- Not defined: counter logic absent, flit_count tied to 0.

## Test plan
- LOCAL injects 8'h21, size 2, payloads A5,5A -> EAST tx 4 consecutive cycles, header on EAST 2 cycles after first push; credit_o[LOCAL] never low.
- WEST and SOUTH each send header 8'h11 size 1 same cycle -> LOCAL gets WEST packet (3 flits) then SOUTH packet, no interleave; repeat -> order alternates.
- Concurrent: EAST->8'h01 and LOCAL->8'h12 -> WEST and NORTH transmit in same cycles.
- credit_i[EAST]=0 for 3 cycles mid-payload -> tx[EAST]=0 those cycles, data resumes unchanged, no flit lost.
- Output blocked, push BUFFER_DEPTH=4 flits -> credit_o low after 4th push, 5th rx ignored; release -> credit_o high one cycle after first pop.
- Reset asserted mid-payload -> all outputs reset values immediately; with ROUTER_FLIT_COUNT_EN, counters 0 and count 3 after a size-1 packet.
